// File: rtl/alu_instr_sequencer_if.sv
// Instruction, ALU, result and debug-read bus of the sequencer.
// master = instruction source / ALU owner, slave = sequencer.
interface alu_instr_sequencer_if #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
) ();
   logic              inValid;
   logic              inReady;
   logic              inLoad;
   logic [2:0]        inOpc;
   logic [REG_AW-1:0] inSrcM;
   logic [REG_AW-1:0] inSrcN;
   logic              inCarry;
   logic [REG_AW-1:0] inDst;
   logic [DATA_W-1:0] inImm;
   logic [DATA_W-1:0] aluM;
   logic [DATA_W-1:0] aluN;
   logic              aluC;
   logic [2:0]        aluOpc;
   logic [DATA_W-1:0] aluF;
   logic              aluZer;
   logic              aluNeg;
   logic              outValid;
   logic [DATA_W-1:0] outData;
   logic              outZer;
   logic              outNeg;
   logic [REG_AW-1:0] rdAddr;
   logic [DATA_W-1:0] rdData;

   modport master (
      output inValid, inLoad, inOpc,
      output inSrcM, inSrcN, inCarry,
      output inDst, inImm,
      input  inReady,
      input  aluM, aluN, aluC, aluOpc,
      output aluF, aluZer, aluNeg,
      input  outValid, outData,
      input  outZer, outNeg,
      output rdAddr,
      input  rdData
   );

   modport slave (
      input  inValid, inLoad, inOpc,
      input  inSrcM, inSrcN, inCarry,
      input  inDst, inImm,
      output inReady,
      output aluM, aluN, aluC, aluOpc,
      input  aluF, aluZer, aluNeg,
      output outValid, outData,
      output outZer, outNeg,
      input  rdAddr,
      output rdData
   );
endinterface

// File: rtl/alu_instr_sequencer.sv
// Multi-cycle sequencer around a combinational ALU:
// fetch operands, execute, write back, or load an immediate.
module alu_instr_sequencer #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
) (
   input logic                 clk,
   input logic                 rst,
   alu_instr_sequencer_if.slave bus
);

   localparam int NREG = 2 ** REG_AW;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      WB
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [DATA_W-1:0] regs [NREG];
   logic [DATA_W-1:0] result;
   logic              zer;
   logic              neg;
   logic [REG_AW-1:0] dst;
   logic              accept;

   assign accept = bus.inValid & bus.inReady;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // next-state: loads skip EXEC since they bypass the ALU
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (accept)
               state_nx = bus.inLoad ? WB : EXEC;
         end
         EXEC:    state_nx = WB;
         WB:      state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // handshake and result strobe decode
   always_comb begin
      bus.inReady  = (state == IDLE);
      bus.outValid = (state == WB);
   end

   // ALU operand registers, held stable through EXEC
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.aluM   <= '0;
         bus.aluN   <= '0;
         bus.aluC   <= 1'b0;
         bus.aluOpc <= 3'd0;
      end else if (accept && !bus.inLoad) begin
         bus.aluM   <= regs[bus.inSrcM];
         bus.aluN   <= regs[bus.inSrcN];
         bus.aluC   <= bus.inCarry;
         bus.aluOpc <= bus.inOpc;
      end
   end

   // destination index captured at accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         dst <= '0;
      else if (accept) dst <= bus.inDst;
   end

   // result/flags: immediate at accept or ALU output after EXEC
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result <= '0;
         zer    <= 1'b0;
         neg    <= 1'b0;
      end else if (accept && bus.inLoad) begin
         result <= bus.inImm;
         zer    <= (bus.inImm == '0);
         neg    <= bus.inImm[DATA_W-1];
      end else if (state == EXEC) begin
         result <= bus.aluF;
         zer    <= bus.aluZer;
         neg    <= bus.aluNeg;
      end
   end

   // register file write-back on the edge leaving WB
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else if (state == WB) begin
         regs[dst] <= result;
      end
   end

   // result port holds the last latched value outside WB
   assign bus.outData = result;
   assign bus.outZer  = zer;
   assign bus.outNeg  = neg;

   assign bus.rdData = regs[bus.rdAddr];

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Randomised self-checking bench for alu_instr_sequencer.
// Bench supplies the combinational ALU and a register-file model.
module tb_alu_instr_sequencer;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   logic [15:0] mdl [8];

   alu_instr_sequencer_if #(.DATA_W(16), .REG_AW(3)) bus ();

   alu_instr_sequencer #(.DATA_W(16), .REG_AW(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] alu_ref(
      input logic [2:0]  op,
      input logic [15:0] m,
      input logic [15:0] n,
      input logic        c
   );
      logic [15:0] r;
      case (op)
         3'd0:    r = m + n + {15'd0, c};
         3'd1:    r = m + {n[15], n[15:1]};
         3'd2:    r = m + 16'd1;
         3'd3:    r = m + {m[15], m[15:1]};
         3'd4:    r = m & n;
         3'd5:    r = m | n;
         3'd6:    r = ~m;
         default: r = 16'd0;
      endcase
      return r;
   endfunction

   // behavioural ALU attached to the sequencer
   always_comb begin
      bus.aluF   = alu_ref(bus.aluOpc, bus.aluM, bus.aluN, bus.aluC);
      bus.aluZer = (bus.aluF == 16'd0);
      bus.aluNeg = bus.aluF[15];
   end

   task automatic scramble();
      bus.inLoad  = 1'($urandom);
      bus.inOpc   = 3'($urandom);
      bus.inSrcM  = 3'($urandom);
      bus.inSrcN  = 3'($urandom);
      bus.inCarry = 1'($urandom);
      bus.inDst   = 3'($urandom);
      bus.inImm   = 16'($urandom);
   endtask

   task automatic drive(
      input bit ld, input bit [2:0] opc,
      input bit [2:0] sm, input bit [2:0] sn,
      input bit c, input bit [2:0] d,
      input bit [15:0] imm
   );
      bus.inValid = 1'b1;
      bus.inLoad  = ld;
      bus.inOpc   = opc;
      bus.inSrcM  = sm;
      bus.inSrcN  = sn;
      bus.inCarry = c;
      bus.inDst   = d;
      bus.inImm   = imm;
   endtask

   // one instruction from a negedge in IDLE to the negedge after write-back
   task automatic run_instr(
      input bit ld, input bit [2:0] opc,
      input bit [2:0] sm, input bit [2:0] sn,
      input bit c, input bit [2:0] d,
      input bit [15:0] imm, input string nm
   );
      logic [15:0] em, en, ef;
      logic        ez, eg;
      int          lat, want;
      em   = mdl[sm];
      en   = mdl[sn];
      ef   = ld ? imm : alu_ref(opc, em, en, c);
      ez   = (ef == 16'd0);
      eg   = ef[15];
      want = ld ? 1 : 2;
      drive(ld, opc, sm, sn, c, d, imm);
      checks++;
      if (bus.inReady !== 1'b1) begin
         errors++;
         $display("FAIL %s ready: got %b want 1", nm, bus.inReady);
      end
      @(posedge clk);
      @(negedge clk);
      bus.inValid = 1'b0;
      scramble();
      lat = 0;
      for (int k = 1; k <= 5; k++) begin
         if (!ld && k == 1) begin
            checks++;
            if ({bus.aluM, bus.aluN, bus.aluC, bus.aluOpc}
                !== {em, en, c, opc}) begin
               errors++;
               $display("FAIL %s alu_in: got %h %h %b %0d want %h %h %b %0d",
                        nm, bus.aluM, bus.aluN, bus.aluC, bus.aluOpc,
                        em, en, c, opc);
            end
         end
         if (bus.outValid === 1'b1) begin
            lat = k;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (lat != want) begin
         errors++;
         $display("FAIL %s latency: got %0d want %0d", nm, lat, want);
      end
      if (lat != 0) begin
         checks++;
         if ({bus.outData, bus.outZer, bus.outNeg} !== {ef, ez, eg}) begin
            errors++;
            $display("FAIL %s result: got %h z%b n%b want %h z%b n%b",
                     nm, bus.outData, bus.outZer, bus.outNeg, ef, ez, eg);
         end
         @(negedge clk);
      end
      checks++;
      if ({bus.outValid, bus.inReady} !== 2'b01) begin
         errors++;
         $display("FAIL %s pulse_end: got v%b r%b want v0 r1",
                  nm, bus.outValid, bus.inReady);
      end
      mdl[d] = ef;
      bus.rdAddr = d;
      #1;
      checks++;
      if (bus.rdData !== ef) begin
         errors++;
         $display("FAIL %s wb r%0d: got %h want %h", nm, d, bus.rdData, ef);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.inValid = 1'b0;
      bus.rdAddr  = 3'd0;
      scramble();
      for (int i = 0; i < 8; i++) mdl[i] = 16'd0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.aluM, bus.aluN, bus.aluC, bus.aluOpc, bus.outValid,
           bus.outData, bus.outZer, bus.outNeg, bus.inReady}
          !== {16'd0, 16'd0, 1'b0, 3'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_outs: got m%h n%h c%b o%0d v%b d%h z%b g%b r%b want zeros r1",
                  bus.aluM, bus.aluN, bus.aluC, bus.aluOpc, bus.outValid,
                  bus.outData, bus.outZer, bus.outNeg, bus.inReady);
      end
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus.rdAddr = 3'(i);
         #1;
         checks++;
         if (bus.rdData !== 16'd0) begin
            errors++;
            $display("FAIL reset_reg r%0d: got %h want 0000", i, bus.rdData);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_load();
      run_instr(1, 0, 0, 0, 0, 1, 16'h0005, "load_r1");
      run_instr(1, 0, 0, 0, 0, 2, 16'hFFF8, "load_r2");
      bus.rdAddr = 3'd1;
      #1;
      checks++;
      if (bus.rdData !== 16'h0005) begin
         errors++;
         $display("FAIL load_r1_keep: got %h want 0005", bus.rdData);
      end
   endtask

   task automatic test_alu_ops();
      run_instr(0, 3'd0, 1, 2, 1, 3, 0, "add_c");
      run_instr(0, 3'd1, 1, 2, 0, 0, 0, "add_sh");
      run_instr(0, 3'd3, 2, 1, 0, 0, 0, "mul15");
      run_instr(0, 3'd7, 1, 2, 0, 0, 0, "zero");
      run_instr(1, 0, 0, 0, 0, 4, 16'hFFFF, "load_r4");
      run_instr(0, 3'd6, 4, 4, 0, 4, 0, "not_self");
   endtask

   task automatic test_back_to_back();
      logic [15:0] e1, e2;
      int          lat;
      e1 = alu_ref(3'd2, mdl[1], mdl[1], 1'b0);
      drive(0, 3'd2, 1, 1, 0, 6, 0);
      @(posedge clk);
      @(negedge clk);
      drive(0, 3'd0, 6, 6, 0, 7, 0);
      checks++;
      if (bus.inReady !== 1'b0) begin
         errors++;
         $display("FAIL b2b ready_exec: got %b want 0", bus.inReady);
      end
      @(negedge clk);
      checks++;
      if ({bus.inReady, bus.outValid, bus.outData} !== {1'b0, 1'b1, e1}) begin
         errors++;
         $display("FAIL b2b wb: got r%b v%b %h want r0 v1 %h",
                  bus.inReady, bus.outValid, bus.outData, e1);
      end
      @(negedge clk);
      mdl[6] = e1;
      e2 = alu_ref(3'd0, e1, e1, 1'b0);
      checks++;
      if ({bus.inReady, bus.outValid} !== 2'b10) begin
         errors++;
         $display("FAIL b2b idle: got r%b v%b want r1 v0",
                  bus.inReady, bus.outValid);
      end
      @(posedge clk);
      @(negedge clk);
      bus.inValid = 1'b0;
      checks++;
      if ({bus.aluM, bus.aluN} !== {e1, e1}) begin
         errors++;
         $display("FAIL b2b dep_read: got %h %h want %h %h",
                  bus.aluM, bus.aluN, e1, e1);
      end
      lat = 0;
      for (int k = 1; k <= 5; k++) begin
         if (bus.outValid === 1'b1) begin
            lat = k;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (lat != 2 || bus.outData !== e2) begin
         errors++;
         $display("FAIL b2b second: got lat %0d %h want lat 2 %h",
                  lat, bus.outData, e2);
      end
      @(negedge clk);
      mdl[7] = e2;
      bus.rdAddr = 3'd7;
      #1;
      checks++;
      if (bus.rdData !== e2) begin
         errors++;
         $display("FAIL b2b r7: got %h want %h", bus.rdData, e2);
      end
   endtask

   task automatic test_reset_midflight();
      drive(0, 3'd2, 1, 1, 0, 5, 0);
      @(posedge clk);
      @(negedge clk);
      bus.inValid = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.outValid, bus.inReady} !== 2'b01) begin
         errors++;
         $display("FAIL rst_exec: got v%b r%b want v0 r1",
                  bus.outValid, bus.inReady);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) mdl[i] = 16'd0;
      repeat (2) @(negedge clk);
      bus.rdAddr = 3'd5;
      #1;
      checks++;
      if ({bus.rdData, bus.outValid, bus.inReady} !== {16'd0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL rst_exec_after: got r5 %h v%b r%b want 0000 v0 r1",
                  bus.rdData, bus.outValid, bus.inReady);
      end
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 2, 16'h1234);
      @(posedge clk);
      @(negedge clk);
      bus.inValid = 1'b0;
      checks++;
      if (bus.outValid !== 1'b1) begin
         errors++;
         $display("FAIL rst_wb_pre: got v%b want 1", bus.outValid);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (bus.outValid !== 1'b0) begin
         errors++;
         $display("FAIL rst_wb_drop: got v%b want 0", bus.outValid);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      bus.rdAddr = 3'd2;
      #1;
      checks++;
      if (bus.rdData !== 16'd0) begin
         errors++;
         $display("FAIL rst_wb_r2: got %h want 0000", bus.rdData);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         bit ld;
         ld = ($urandom_range(0, 3) == 0);
         run_instr(ld, 3'($urandom), 3'($urandom), 3'($urandom),
                   1'($urandom), 3'($urandom), 16'($urandom), "rand");
      end
      for (int i = 0; i < 8; i++) begin
         bus.rdAddr = 3'(i);
         #1;
         checks++;
         if (bus.rdData !== mdl[i]) begin
            errors++;
            $display("FAIL rand_regs r%0d: got %h want %h",
                     i, bus.rdData, mdl[i]);
         end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_load();
      test_alu_ops();
      test_back_to_back();
      test_reset_midflight();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
